osc_wave_shaper: RTL and testbench

Per-slot waveform shaper directly downstream of the oscillator phase accumulator stage. Converts each time-multiplexed 11-bit oscillator phase into a signed 16-bit sample (saw, pulse, triangle, parabolic sine, optional noise) and scales it by a per-slot level. Voice/oscillator tags ride alongside the pipeline, so the mixer downstream receives tagged samples with fixed latency.

---
 rtl/osc_wave_shaper.sv | 156 +++++++++++++++
 tb/tb_osc_wave_shaper.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/osc_wave_shaper.sv
// osc_wave_shaper: three-stage shaper turning a time-multiplexed 11-bit
// oscillator phase into a signed 16-bit sample scaled by a per-slot level.
// Stage 1 registers the slot, stage 2 shapes the waveform, stage 3 applies gain.
// Voice/oscillator tags and the valid bit travel with the data (latency 3).
// Build option: define OSC_NOISE_EN to add the 16-bit LFSR noise source on
// wave_sel=4; without it wave_sel=4 is silence.
module osc_wave_shaper #(
   parameter int VOICES  = 8,
   parameter int V_OSC   = 4,
   parameter int V_WIDTH = 3,
   parameter int O_WIDTH = 2
) (
   input  logic               OSC_CLK,
   input  logic               reg_reset,
   input  logic               phase_valid,
   input  logic [10:0]        phase_acc,
   input  logic [V_WIDTH-1:0] vx,
   input  logic [O_WIDTH-1:0] ox,
   input  logic [2:0]         wave_sel,
   input  logic [10:0]        pulse_width,
   input  logic [7:0]         level,
   output logic               sample_valid,
   output logic [15:0]        sample_out,
   output logic [V_WIDTH-1:0] sample_vx,
   output logic [O_WIDTH-1:0] sample_ox
);

   // Tags must be wide enough to name every voice and oscillator.
   if (VOICES > (1 << V_WIDTH) || V_OSC > (1 << O_WIDTH)) begin : g_tag_check
      $error("osc_wave_shaper: tag width too narrow for VOICES/V_OSC");
   end

   logic               s1_valid;
   logic [10:0]        s1_phase;
   logic [V_WIDTH-1:0] s1_vx;
   logic [O_WIDTH-1:0] s1_ox;
   logic [2:0]         s1_sel;
   logic [10:0]        s1_pw;
   logic [7:0]         s1_level;

   logic               s2_valid;
   logic signed [15:0] s2_raw;
   logic [7:0]         s2_level;
   logic [V_WIDTH-1:0] s2_vx;
   logic [O_WIDTH-1:0] s2_ox;

   logic [9:0]         h;
   logic [10:0]        h_comp;
   logic [18:0]        sine_y;
   logic [15:0]        sine_m;
   logic [15:0]        sine_sat;
   logic [15:0]        noise;
   logic [15:0]        raw_next;
   logic signed [8:0]  gain;
   logic signed [24:0] prod;

   // Stage 1: capture the slot; data only on valid, valid bit every cycle.
   always_ff @(posedge OSC_CLK or posedge reg_reset) begin
      if (reg_reset) begin
         s1_valid <= 1'b0;
         s1_phase <= '0;
         s1_vx    <= '0;
         s1_ox    <= '0;
         s1_sel   <= '0;
         s1_pw    <= '0;
         s1_level <= '0;
      end else begin
         s1_valid <= phase_valid;
         if (phase_valid) begin
            s1_phase <= phase_acc;
            s1_vx    <= vx;
            s1_ox    <= ox;
            s1_sel   <= wave_sel;
            s1_pw    <= pulse_width;
            s1_level <= level;
         end
      end
   end

   assign h        = s1_phase[9:0];
   assign h_comp   = 11'd1024 - {1'b0, h};
   // Parabola peaks at h=512 with y=262144, so y>>3 can reach 32768.
   assign sine_y   = {9'd0, h} * {8'd0, h_comp};
   assign sine_m   = sine_y[18:3];
   assign sine_sat = (sine_m > 16'd32767) ? 16'h7FFF : sine_m;

`ifdef OSC_NOISE_EN
   logic [15:0] lfsr;

   // Fibonacci LFSR (taps 16,14,13,11), steps once per valid stage-2 slot.
   always_ff @(posedge OSC_CLK or posedge reg_reset) begin
      if (reg_reset)     lfsr <= 16'hACE1;
      else if (s1_valid) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   end

   assign noise = lfsr;
`else
   assign noise = 16'd0;
`endif

   // Stage 2 shaping; every result fits 16-bit two's complement, so modular
   // 16-bit arithmetic yields the exact signed value.
   always_comb begin
      raw_next = 16'd0;
      case (s1_sel)
         3'd0: raw_next = {~s1_phase[10], s1_phase[9:0], 5'd0};
         3'd1: raw_next = (s1_phase < s1_pw) ? 16'h7FFF : 16'h8001;
         3'd2: raw_next = s1_phase[10] ? (16'h7FFF - {h, 6'd0})
                                       : ({h, 6'd0} - 16'h8000);
         3'd3: raw_next = s1_phase[10] ? (16'd0 - sine_sat) : sine_sat;
         3'd4: raw_next = noise;
         default: raw_next = 16'd0;
      endcase
   end

   // Stage 2 register: shaped sample plus the slot's level and tags.
   always_ff @(posedge OSC_CLK or posedge reg_reset) begin
      if (reg_reset) begin
         s2_valid <= 1'b0;
         s2_raw   <= '0;
         s2_level <= '0;
         s2_vx    <= '0;
         s2_ox    <= '0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_raw   <= raw_next;
            s2_level <= s1_level;
            s2_vx    <= s1_vx;
            s2_ox    <= s1_ox;
         end
      end
   end

   // Level is unsigned, so zero-extend before the signed multiply; >>> floors.
   assign gain = {1'b0, s2_level};
   assign prod = s2_raw * gain;

   // Stage 3: scaled output; holds its last slot while no valid arrives.
   always_ff @(posedge OSC_CLK or posedge reg_reset) begin
      if (reg_reset) begin
         sample_valid <= 1'b0;
         sample_out   <= '0;
         sample_vx    <= '0;
         sample_ox    <= '0;
      end else begin
         sample_valid <= s2_valid;
         if (s2_valid) begin
            sample_out <= 16'(prod >>> 8);
            sample_vx  <= s2_vx;
            sample_ox  <= s2_ox;
         end
      end
   end

endmodule

// File: tb/tb_osc_wave_shaper.sv
// Directed bench for osc_wave_shaper: reset, each waveform, latency, gaps,
// hold behaviour, noise sequence and reset with slots in flight.
module tb_osc_wave_shaper;

   logic        osc_clk = 1'b0;
   logic        reg_reset;
   logic        phase_valid;
   logic [10:0] phase_acc;
   logic [2:0]  vx;
   logic [1:0]  ox;
   logic [2:0]  wave_sel;
   logic [10:0] pulse_width;
   logic [7:0]  level;
   logic        sample_valid;
   logic [15:0] sample_out;
   logic [2:0]  sample_vx;
   logic [1:0]  sample_ox;

   int errors = 0;
   int checks = 0;

   always #5 osc_clk = ~osc_clk;

   osc_wave_shaper #(.VOICES(8), .V_OSC(4), .V_WIDTH(3), .O_WIDTH(2)) dut (
      .OSC_CLK(osc_clk), .reg_reset(reg_reset), .phase_valid(phase_valid),
      .phase_acc(phase_acc), .vx(vx), .ox(ox), .wave_sel(wave_sel),
      .pulse_width(pulse_width), .level(level), .sample_valid(sample_valid),
      .sample_out(sample_out), .sample_vx(sample_vx), .sample_ox(sample_ox)
   );

   task automatic step();
      @(posedge osc_clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [10:0] p, input logic [2:0] sel,
                        input logic [10:0] pw, input logic [7:0] lvl,
                        input logic [2:0] t_vx, input logic [1:0] t_ox);
      phase_valid = v;
      phase_acc   = p;
      wave_sel    = sel;
      pulse_width = pw;
      level       = lvl;
      vx          = t_vx;
      ox          = t_ox;
   endtask

   task automatic test_reset();
      drive(1'b0, 11'd0, 3'd0, 11'd0, 8'd0, 3'd0, 2'd0);
      reg_reset = 1'b1;
      step();
      step();
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
      checks++; if (sample_out !== 16'd0) begin errors++; $display("FAIL reset_out: got %h want 0000", sample_out); end
      checks++; if (sample_vx !== 3'd0) begin errors++; $display("FAIL reset_vx: got %0d want 0", sample_vx); end
      checks++; if (sample_ox !== 2'd0) begin errors++; $display("FAIL reset_ox: got %0d want 0", sample_ox); end
      reg_reset = 1'b0;
      step();
   endtask

   // One slot at a time so the exact 3-cycle latency is visible.
   task automatic test_saw();
      logic [10:0] p_tab [3] = '{11'd0, 11'd1024, 11'd2047};
      logic [15:0] e_tab [3] = '{-16'sd32640, 16'sd0, 16'sd32608};
      for (int i = 0; i < 3; i++) begin
         step();
         drive(1'b1, p_tab[i], 3'd0, 11'd0, 8'd255, 3'(i + 1), 2'd1);
         step();
         phase_valid = 1'b0;
         checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL saw_lat1[%0d]: got %b want 0", i, sample_valid); end
         step();
         checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL saw_lat2[%0d]: got %b want 0", i, sample_valid); end
         step();
         checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL saw_lat3[%0d]: got %b want 1", i, sample_valid); end
         checks++; if (sample_out !== e_tab[i]) begin errors++; $display("FAIL saw_out[%0d]: got %0d want %0d", i, $signed(sample_out), $signed(e_tab[i])); end
         checks++; if (sample_vx !== 3'(i + 1)) begin errors++; $display("FAIL saw_vx[%0d]: got %0d want %0d", i, sample_vx, i + 1); end
      end
   endtask

   // Back-to-back sine slots; -32767*255 floors to -32640 under >>>8.
   task automatic test_sine();
      logic [10:0] p_tab [4] = '{11'd512, 11'd1536, 11'd0, 11'd1024};
      logic [15:0] e_tab [4] = '{16'sd32639, -16'sd32640, 16'sd0, 16'sd0};
      for (int c = 0; c < 8; c++) begin
         step();
         if (c == 1 || c == 2) begin
            checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL sine_early[%0d]: got %b want 0", c, sample_valid); end
         end
         if (c >= 3 && c < 7) begin
            checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL sine_valid[%0d]: got %b want 1", c - 3, sample_valid); end
            checks++; if (sample_out !== e_tab[c-3]) begin errors++; $display("FAIL sine_out[%0d]: got %0d want %0d", c - 3, $signed(sample_out), $signed(e_tab[c-3])); end
            checks++; if (sample_vx !== 3'd5 || sample_ox !== 2'd3) begin errors++; $display("FAIL sine_tag[%0d]: got %0d/%0d want 5/3", c - 3, sample_vx, sample_ox); end
         end
         if (c == 7) begin
            checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL sine_end: got %b want 0", sample_valid); end
         end
         if (c < 4) drive(1'b1, p_tab[c], 3'd3, 11'd0, 8'd255, 3'd5, 2'd3);
         else       phase_valid = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      logic [10:0] p_tab [2] = '{11'd99, 11'd100};
      logic [15:0] e_tab [2] = '{16'sd16383, -16'sd16384};
      for (int c = 0; c < 6; c++) begin
         step();
         if (c == 3 || c == 4) begin
            checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL pulse_valid[%0d]: got %b want 1", c - 3, sample_valid); end
            checks++; if (sample_out !== e_tab[c-3]) begin errors++; $display("FAIL pulse_out[%0d]: got %0d want %0d", c - 3, $signed(sample_out), $signed(e_tab[c-3])); end
            checks++; if (sample_vx !== 3'(c - 1)) begin errors++; $display("FAIL pulse_vx[%0d]: got %0d want %0d", c - 3, sample_vx, c - 1); end
         end
         if (c == 5) begin
            checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL pulse_gap_valid: got %b want 0", sample_valid); end
            checks++; if (sample_out !== 16'hC000) begin errors++; $display("FAIL pulse_hold_out: got %0d want -16384", $signed(sample_out)); end
            checks++; if (sample_vx !== 3'd3) begin errors++; $display("FAIL pulse_hold_vx: got %0d want 3", sample_vx); end
         end
         if (c < 2) drive(1'b1, p_tab[c], 3'd1, 11'd100, 8'd128, 3'(c + 2), 2'd1);
         else       drive(1'b0, 11'd5, 3'd1, 11'd100, 8'd128, 3'd6, 2'd0);
      end
   endtask

   // Level 0 triangle with a 1,0,1,1 valid pattern; tags hold through the gap.
   task automatic test_triangle_gaps();
      logic        v_tab [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic [10:0] p_tab [4] = '{11'd300, 11'd999, 11'd1500, 11'd2000};
      logic [2:0]  t_tab [4] = '{3'd1, 3'd6, 3'd2, 3'd4};
      for (int c = 0; c < 8; c++) begin
         step();
         if (c >= 3 && c < 7) begin
            checks++; if (sample_valid !== v_tab[c-3]) begin errors++; $display("FAIL tri_valid[%0d]: got %b want %b", c - 3, sample_valid, v_tab[c-3]); end
            checks++; if (sample_out !== 16'd0) begin errors++; $display("FAIL tri_out[%0d]: got %0d want 0", c - 3, $signed(sample_out)); end
         end
         if (c == 4) begin
            checks++; if (sample_vx !== 3'd1) begin errors++; $display("FAIL tri_gap_vx: got %0d want 1", sample_vx); end
         end
         if (c == 6) begin
            checks++; if (sample_vx !== 3'd4) begin errors++; $display("FAIL tri_last_vx: got %0d want 4", sample_vx); end
         end
         if (c < 4) drive(v_tab[c], p_tab[c], 3'd2, 11'd0, 8'd0, t_tab[c], 2'd2);
         else       phase_valid = 1'b0;
      end
   endtask

   task automatic test_noise();
      logic [15:0] e_tab [3];
`ifdef OSC_NOISE_EN
      // raw 16'hACE1, 16'h5670, 16'hAB38 scaled by 255/256 with flooring
      e_tab = '{-16'sd21196, 16'sd22041, -16'sd21620};
`else
      e_tab = '{16'sd0, 16'sd0, 16'sd0};
`endif
      reg_reset = 1'b1;
      phase_valid = 1'b0;
      step();
      reg_reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (c >= 3) begin
            checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL noise_valid[%0d]: got %b want 1", c - 3, sample_valid); end
            checks++; if (sample_out !== e_tab[c-3]) begin errors++; $display("FAIL noise_out[%0d]: got %0d want %0d", c - 3, $signed(sample_out), $signed(e_tab[c-3])); end
         end
         if (c < 3) drive(1'b1, 11'd0, 3'd4, 11'd0, 8'd255, 3'd7, 2'd0);
         else       phase_valid = 1'b0;
      end
      // Two more noise slots, then reset before either emerges.
      step();
      drive(1'b1, 11'd0, 3'd4, 11'd0, 8'd255, 3'd3, 2'd1);
      step();
      step();
      phase_valid = 1'b0;
      reg_reset = 1'b1;
      step();
      step();
      reg_reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step();
         checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL noise_flush[%0d]: got %b want 0", c, sample_valid); end
      end
      drive(1'b1, 11'd0, 3'd4, 11'd0, 8'd255, 3'd2, 2'd2);
      step();
      phase_valid = 1'b0;
      step();
      step();
      checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL noise_restart_valid: got %b want 1", sample_valid); end
      checks++; if (sample_out !== e_tab[0]) begin errors++; $display("FAIL noise_restart_out: got %0d want %0d", $signed(sample_out), $signed(e_tab[0])); end
   endtask

   task automatic test_reset_in_flight();
      int pulses = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         drive(1'b1, 11'd2047, 3'd0, 11'd0, 8'd255, 3'd6, 2'd3);
      end
      #1;
      reg_reset = 1'b1;
      phase_valid = 1'b0;
      #1;
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rif_valid: got %b want 0", sample_valid); end
      checks++; if (sample_out !== 16'd0) begin errors++; $display("FAIL rif_out: got %h want 0000", sample_out); end
      checks++; if (sample_vx !== 3'd0 || sample_ox !== 2'd0) begin errors++; $display("FAIL rif_tag: got %0d/%0d want 0/0", sample_vx, sample_ox); end
      step();
      step();
      reg_reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (sample_valid === 1'b1) pulses++;
      end
      checks++; if (pulses != 0) begin errors++; $display("FAIL rif_ghost_slots: got %0d want 0", pulses); end
      checks++; if (sample_out !== 16'd0) begin errors++; $display("FAIL rif_out_after: got %h want 0000", sample_out); end
      drive(1'b1, 11'd2047, 3'd0, 11'd0, 8'd255, 3'd7, 2'd2);
      step();
      phase_valid = 1'b0;
      step();
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rif_first_early: got %b want 0", sample_valid); end
      step();
      checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL rif_first_valid: got %b want 1", sample_valid); end
      checks++; if (sample_out !== 16'sd32608) begin errors++; $display("FAIL rif_first_out: got %0d want 32608", $signed(sample_out)); end
      checks++; if (sample_vx !== 3'd7 || sample_ox !== 2'd2) begin errors++; $display("FAIL rif_first_tag: got %0d/%0d want 7/2", sample_vx, sample_ox); end
   endtask

   initial begin
      reg_reset = 1'b1;
      drive(1'b0, 11'd0, 3'd0, 11'd0, 8'd0, 3'd0, 2'd0);
      test_reset();
      test_saw();
      test_sine();
      test_back_to_back();
      test_triangle_gaps();
      test_noise();
      test_reset_in_flight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
